// File: rtl/ifmap_feeder.sv
// ifmap_feeder: reads a row_count x row_len IFMap tile from a synchronous
// source memory, tags every pixel with start/end-of-row flags and pushes the
// tagged words into the PE IFMap FIFO under full backpressure.
// Optional feature macro: IFMAP_FEEDER_PAD_EN frames each row with a leading
// pad word {1,0,0} and a trailing pad word {0,1,0}; pixels then carry no flags.
module ifmap_feeder #(
   parameter int PIXEL_WIDTH = 16,
   parameter int IFMAP_WIDTH = 18,
   parameter int ADDR_WIDTH  = 10,
   parameter int LEN_WIDTH   = 8,
   parameter int ROWS_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [LEN_WIDTH-1:0]   row_len,
   input  logic [ROWS_WIDTH-1:0]  row_count,
   output logic                   mem_ren,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [PIXEL_WIDTH-1:0] mem_rdata,
   input  logic                   buf_full,
   output logic                   buf_wen,
   output logic [IFMAP_WIDTH-1:0] buf_din,
   output logic                   busy,
   output logic                   done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_LOAD,
      S_SEND,
`ifdef IFMAP_FEEDER_PAD_EN
      S_PAD,
`endif
      S_FIN
   } state_t;

`ifdef IFMAP_FEEDER_PAD_EN
   // Which kind of word SEND is presenting.
   typedef enum logic [1:0] {K_PIX, K_LPAD, K_RPAD} kind_t;
   kind_t kind_q, kind_d;
`endif

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q,  addr_d;
   logic [LEN_WIDTH-1:0]   col_q,   col_d;
   logic [ROWS_WIDTH-1:0]  row_q,   row_d;
   logic [LEN_WIDTH-1:0]   len_q,   len_d;
   logic [ROWS_WIDTH-1:0]  rows_q,  rows_d;
   logic [PIXEL_WIDTH-1:0] hold_q,  hold_d;

   logic first_col;
   logic last_col;
   logic last_row;

   // Position decode inside the latched tile geometry (only meaningful while busy,
   // where len_q and rows_q are known to be non-zero).
   assign first_col = (col_q == '0);
   assign last_col  = (col_q == len_q - LEN_WIDTH'(1));
   assign last_row  = (row_q == rows_q - ROWS_WIDTH'(1));

   // State register plus tile bookkeeping; everything clears on reset.
   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of its peers regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         len_q   <= '0;
         rows_q  <= '0;
         hold_q  <= '0;
`ifdef IFMAP_FEEDER_PAD_EN
         kind_q  <= K_PIX;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         len_q   <= len_d;
         rows_q  <= rows_d;
         hold_q  <= hold_d;
`ifdef IFMAP_FEEDER_PAD_EN
         kind_q  <= kind_d;
`endif
      end
   end

   // Next-state and counter/address update logic.
   // NOTE: every signal gets its hold value first so no path through the case
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      col_d   = col_q;
      row_d   = row_q;
      len_d   = len_q;
      rows_d  = rows_q;
      hold_d  = hold_q;
`ifdef IFMAP_FEEDER_PAD_EN
      kind_d  = kind_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d = base_addr;
               len_d  = row_len;
               rows_d = row_count;
               col_d  = '0;
               row_d  = '0;
               if (row_len == '0 || row_count == '0) begin
                  state_d = S_FIN;
               end else begin
`ifdef IFMAP_FEEDER_PAD_EN
                  state_d = S_PAD;
                  kind_d  = K_LPAD;
`else
                  state_d = S_READ;
`endif
               end
            end
         end
         S_READ: begin
            state_d = S_LOAD;
`ifdef IFMAP_FEEDER_PAD_EN
            kind_d  = K_PIX;
`endif
         end
         S_LOAD: begin
            hold_d  = mem_rdata;
            state_d = S_SEND;
         end
`ifdef IFMAP_FEEDER_PAD_EN
         S_PAD: state_d = S_SEND;
`endif
         S_SEND: begin
            if (!buf_full) begin
`ifdef IFMAP_FEEDER_PAD_EN
               unique case (kind_q)
                  K_LPAD: state_d = S_READ;
                  K_RPAD: begin
                     row_d   = row_q + ROWS_WIDTH'(1);
                     kind_d  = K_LPAD;
                     state_d = last_row ? S_FIN : S_PAD;
                  end
                  default: begin
                     addr_d = addr_q + ADDR_WIDTH'(1);
                     if (last_col) begin
                        col_d   = '0;
                        kind_d  = K_RPAD;
                        state_d = S_PAD;
                     end else begin
                        col_d   = col_q + LEN_WIDTH'(1);
                        state_d = S_READ;
                     end
                  end
               endcase
`else
               addr_d = addr_q + ADDR_WIDTH'(1);
               if (last_col) begin
                  col_d   = '0;
                  row_d   = row_q + ROWS_WIDTH'(1);
                  state_d = last_row ? S_FIN : S_READ;
               end else begin
                  col_d   = col_q + LEN_WIDTH'(1);
                  state_d = S_READ;
               end
`endif
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode from registered state; buf_full is the only input that
   // reaches an output combinationally.
   always_comb begin
      mem_ren  = (state_q == S_READ);
      mem_addr = (state_q == S_READ) ? addr_q : '0;
      buf_wen  = (state_q == S_SEND) && !buf_full;
      buf_din  = '0;
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_FIN);
      if (state_q == S_SEND) begin
`ifdef IFMAP_FEEDER_PAD_EN
         unique case (kind_q)
            K_LPAD:  buf_din = {2'b10, {PIXEL_WIDTH{1'b0}}};
            K_RPAD:  buf_din = {2'b01, {PIXEL_WIDTH{1'b0}}};
            default: buf_din = {2'b00, hold_q};
         endcase
`else
         buf_din = {first_col, last_col, hold_q};
`endif
      end
   end

endmodule

// File: tb/tb_ifmap_feeder.sv
// Self-checking bench for ifmap_feeder: a queue-based scoreboard filled from a
// tile-level reference model, drained by a negedge monitor.
module tb_ifmap_feeder;

   localparam int PW = 16;
   localparam int IW = 18;
   localparam int AW = 10;
   localparam int LW = 8;
   localparam int RW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [LW-1:0] row_len;
   logic [RW-1:0] row_count;
   logic          mem_ren;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_rdata = '0;
   logic          buf_full = 1'b0;
   logic          buf_wen;
   logic [IW-1:0] buf_din;
   logic          busy;
   logic          done;

   ifmap_feeder #(
      .PIXEL_WIDTH(PW), .IFMAP_WIDTH(IW), .ADDR_WIDTH(AW),
      .LEN_WIDTH(LW), .ROWS_WIDTH(RW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .row_len(row_len), .row_count(row_count), .mem_ren(mem_ren),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .buf_full(buf_full),
      .buf_wen(buf_wen), .buf_din(buf_din), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

`ifdef IFMAP_FEEDER_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   // Source memory model: random contents, one-cycle read latency.
   logic [PW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [AW-1:0] aq[$];   // expected read addresses
   logic [IW-1:0] wq[$];   // expected FIFO words

   int rd_cnt = 0, rd_last_cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = 0;
   int wr_cyc [0:4095];
   bit rand_bp = 1'b0, stall_arm = 1'b0, stall_chk = 1'b0, stall_prev = 1'b0;
   int stall_rd = 0, stall_left = 0;
   logic [IW-1:0] stall_din = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {mem_ren, mem_addr, buf_wen, buf_din, busy, done};
   endfunction

   // Reference model: enumerate the tile row by row from the addressing rule.
   task automatic build_tile(input int base, input int len, input int rows, output int nwords);
      nwords = 0;
      if (len == 0 || rows == 0) return;
      for (int r = 0; r < rows; r++) begin
         if (PAD) begin wq.push_back({2'b10, 16'h0}); nwords++; end
         for (int k = 0; k < len; k++) begin
            int a;
            logic [1:0] fl;
            a  = (base + r * len + k) % (1 << AW);
            fl = PAD ? 2'b00 : {k == 0, k == len - 1};
            aq.push_back(AW'(a));
            wq.push_back({fl, mem[a]});
            nwords++;
         end
         if (PAD) begin wq.push_back({2'b01, 16'h0}); nwords++; end
      end
   endtask

   // Monitor: pops and compares whenever the DUT reads memory or writes the FIFO.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         if (mem_ren) begin
            rd_cnt++;
            rd_last_cyc = cyc;
            if (aq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_mem_ren: got addr 0x%0h, expected no read", mem_addr);
            end else check("mem_addr", mem_addr, aq.pop_front());
         end
         if (buf_wen) begin
            check("wen_while_full", buf_full, 0);
            wr_cyc[wr_cnt % 4096] = cyc;
            wr_cnt++;
            if (wq.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_buf_wen: got din 0x%0h, expected no write", buf_din);
            end else check("buf_din", buf_din, wq.pop_front());
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (stall_chk) begin
            check("stall_wen", buf_wen, 0);
            if (stall_prev) check("stall_din_stable", buf_din, stall_din);
            stall_din  = buf_din;
            stall_prev = 1'b1;
         end else stall_prev = 1'b0;
      end
   end

   // Backpressure driver: random full, or a directed 5-cycle stall on the
   // SEND that follows the armed read.
   initial forever begin
      @(posedge clk); #1;
      if (rand_bp) buf_full = ($urandom_range(0, 2) == 0);
      else if (stall_left > 0) begin
         stall_left--;
         if (stall_left == 0) begin buf_full = 1'b0; stall_chk = 1'b0; end
      end else if (stall_arm && rd_cnt >= stall_rd && cyc == rd_last_cyc + 2) begin
         buf_full = 1'b1; stall_left = 5; stall_arm = 1'b0; stall_chk = 1'b1;
      end else buf_full = 1'b0;
   end

   task automatic run_tile(input int base, input int len, input int rows, input bit bp, input bit intf);
      int nw, wr0, dn0, c0, n;
      build_tile(base, len, rows, nw);
      wr0 = wr_cnt; dn0 = done_cnt;
      @(posedge clk); #1;
      base_addr = AW'(base); row_len = LW'(len); row_count = RW'(rows); start = 1'b1;
      c0 = cyc;
      if (bp) begin stall_rd = rd_cnt + 2; stall_arm = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0; base_addr = AW'($urandom); row_len = LW'($urandom); row_count = RW'($urandom);
      if (intf) begin
         n = 0;
         while (wr_cnt == wr0 && n < 200) begin @(negedge clk); n++; end
         @(posedge clk); #1;
         start = 1'b1; base_addr = 10'h2AA; row_len = 8'd7; row_count = 8'd5;
         @(posedge clk); #1;
         start = 1'b0;
      end
      n = 0;
      while (done_cnt == dn0 && n < 4000) begin @(negedge clk); n++; end
      if (done_cnt == dn0) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected a pulse", n);
      end
      repeat (6) @(negedge clk);
      check("write_count", wr_cnt - wr0, nw);
      check("done_pulses", done_cnt - dn0, 1);
      check("words_left", wq.size(), 0);
      check("reads_left", aq.size(), 0);
      if (nw > 0) begin
         if (!rand_bp && !bp) check("first_wen_latency", wr_cyc[wr0 % 4096] - c0, PAD ? 2 : 3);
         check("done_after_last_write", done_cyc - wr_cyc[(wr_cnt - 1) % 4096], 1);
      end else check("done_latency_empty", done_cyc - c0, 1);
      aq.delete(); wq.delete();
   endtask

   task automatic abort_tile();
      int nw, wr0, dn0, n;
      build_tile(32'h040, 4, 3, nw);
      wr0 = wr_cnt;
      @(posedge clk); #1;
      base_addr = 10'h040; row_len = 8'd4; row_count = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (wr_cnt < wr0 + 2 && n < 200) begin @(negedge clk); n++; end
      check("abort_reached_writes", wr_cnt - wr0, 2);
      dn0 = done_cnt;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 check("abort_outputs_now", outs(), 0);
      repeat (3) begin @(negedge clk); check("abort_outputs_held", outs(), 0); end
      check("abort_no_done", done_cnt - dn0, 0);
      aq.delete(); wq.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("after_abort_idle", outs(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = PW'($urandom);
      rst = 1'b0; start = 1'b0; base_addr = '0; row_len = '0; row_count = '0;
      // Reset: random inputs must not reach any output.
      rand_bp = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         start = 1'($urandom); base_addr = AW'($urandom);
         row_len = LW'($urandom); row_count = RW'($urandom);
         @(negedge clk);
         check("reset_outputs", outs(), 0);
      end
      rand_bp = 1'b0;
      start = 1'b0; base_addr = '0; row_len = '0; row_count = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("idle_after_reset", outs(), 0);

      run_tile(32'h010, 3, 2, 1'b0, 1'b0);   // basic tile
      run_tile(32'h010, 3, 2, 1'b1, 1'b0);   // 5-cycle stall on 2nd SEND
      run_tile(32'h123, 1, 3, 1'b0, 1'b0);   // 1-pixel rows
      run_tile(32'h050, 0, 5, 1'b0, 1'b0);   // empty rows
      run_tile(32'h050, 5, 0, 1'b0, 1'b0);   // no rows
      run_tile(32'h3FE, 4, 1, 1'b0, 1'b0);   // address wrap
      run_tile(32'h100, 3, 2, 1'b0, 1'b1);   // start while busy
      run_tile(32'h020, 2, 1, 1'b0, 1'b0);   // short tile (pad framing when enabled)
      abort_tile();
      run_tile(32'h200, 2, 2, 1'b0, 1'b0);   // recovery after abort

      rand_bp = 1'b1;
      for (int t = 0; t < 10; t++)
         run_tile(int'($urandom_range(0, 1023)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 4)), 1'b0, 1'b0);
      rand_bp = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
